// File: rtl/qpsk_capture_sequencer.sv
// qpsk_capture_sequencer
// Steers decimated IQ samples into the IQ BRAM for one capture: a circular
// pre-trigger fill, one timestamp word at the accepted second marker, then a
// fixed-length post-trigger run, after which the buffer is frozen for readout.
module qpsk_capture_sequencer #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int PRE_LEN = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cic_40_pulse,
    input  logic [DATA_W-1:0] iq_data,
    input  logic              sec_marker,
    input  logic [DATA_W-1:0] timestamp,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] post_len,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int                FILL_W    = $clog2(PRE_LEN + 1);
    localparam logic [FILL_W-1:0] PRE_LEN_C = FILL_W'(PRE_LEN);
    // Longest post run that cannot wrap onto this capture's own
    // pre-trigger window and timestamp word.
    localparam logic [ADDR_W-1:0] MAX_POST  = ADDR_W'((2 ** ADDR_W) - 1 - PRE_LEN);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [FILL_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] post_len_q;
    logic              ts_pending;
    logic [DATA_W-1:0] ts_q;

    logic active;
    logic trig;
    logic arm_ok;
    logic post_full;
    logic do_sample;
    logic do_ts;

    // Decode this cycle's write slot and the next state.
    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        active    = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
        trig      = (state == S_ARMED) && sec_marker;
        arm_ok    = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
        post_full = (state == S_POST) && !ts_pending && (post_cnt == post_len_q);
        // Samples own the write slot; the timestamp takes the next free one.
        do_sample = !abort && active && cic_40_pulse && !post_full;
        do_ts     = !abort && !do_sample && (ts_pending || trig);

        state_nxt = state;
        case (state)
            S_IDLE:  if (arm_ok) state_nxt = S_FILL;
            S_FILL:  if (fill_cnt == PRE_LEN_C) state_nxt = S_ARMED;
            S_ARMED: if (sec_marker) state_nxt = S_POST;
            S_POST:  if (post_full) state_nxt = S_DONE;
            S_DONE:  if (arm_ok) state_nxt = S_FILL;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Hold the marker's timestamp until a free write slot comes up.
    // NOTE: ts_q is pure datapath, only read while ts_pending is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (trig) ts_q <= timestamp;
    end

    // State, pointers, counters and the registered BRAM write port.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            trig_addr  <= '0;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            post_len_q <= '0;
            ts_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_FILL) || (state_nxt == S_ARMED) || (state_nxt == S_POST);
            done  <= (state_nxt == S_DONE);

            bram_we <= do_sample || do_ts;
            if (do_sample) begin
                bram_addr <= wr_ptr;
                bram_din  <= iq_data;
            end else if (do_ts) begin
                bram_addr <= wr_ptr;
                bram_din  <= ts_pending ? ts_q : timestamp;
                trig_addr <= wr_ptr;
            end

            // Abort drops a timestamp that has not been written yet.
            ts_pending <= !abort && (ts_pending || trig) && !do_ts;

            if (arm_ok) begin
                wr_ptr     <= '0;
                fill_cnt   <= '0;
                post_cnt   <= '0;
                post_len_q <= (post_len > MAX_POST) ? MAX_POST : post_len;
            end else begin
                if (do_sample || do_ts) wr_ptr <= wr_ptr + 1'b1;
                if (do_sample && (fill_cnt != PRE_LEN_C)) fill_cnt <= fill_cnt + 1'b1;
                // Only samples landing after the timestamp word count as post-trigger.
                if (do_sample && (state == S_POST) && !ts_pending) post_cnt <= post_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_capture_sequencer.sv
// tb_qpsk_capture_sequencer
// Directed bench on a small instance (ADDR_W=4, PRE_LEN=4): idle pulses,
// a basic capture, marker during fill, coincident marker/sample, pointer
// wrap with post_len clamping, and abort followed by re-arm.
module tb_qpsk_capture_sequencer;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int PRE_LEN = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cic_40_pulse = 1'b0;
    logic [DATA_W-1:0] iq_data = '0;
    logic              sec_marker = 1'b0;
    logic [DATA_W-1:0] timestamp = '0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] post_len = '0;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [ADDR_W-1:0] trig_addr;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [DATA_W-1:0] wd[$];

    qpsk_capture_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PRE_LEN(PRE_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cic_40_pulse(cic_40_pulse),
        .iq_data     (iq_data),
        .sec_marker  (sec_marker),
        .timestamp   (timestamp),
        .arm         (arm),
        .abort       (abort),
        .post_len    (post_len),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .trig_addr   (trig_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge and every
    // BRAM write seen there is appended to the write log.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bram_we) begin
            wa.push_back(bram_addr);
            wd.push_back(bram_din);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [DATA_W-1:0] d);
        cic_40_pulse = 1'b1;
        iq_data      = d;
        tick();
        cic_40_pulse = 1'b0;
    endtask

    task automatic marker(input logic [DATA_W-1:0] ts);
        sec_marker = 1'b1;
        timestamp  = ts;
        tick();
        sec_marker = 1'b0;
    endtask

    task automatic do_arm(input logic [ADDR_W-1:0] len);
        arm      = 1'b1;
        post_len = len;
        tick();
        arm      = 1'b0;
        post_len = '0;
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        n_checks++;
        assert (idx < wa.size()) else begin
            n_errors++;
            $error("FAIL %s_present: observed=%0d writes expected>%0d", tag, wa.size(), idx);
        end
        if (idx < wa.size()) begin
            chk($sformatf("%s_addr", tag), 32'(wa[idx]), 32'(a));
            chk($sformatf("%s_data", tag), wd[idx], d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset values.
        idle(2);
        chk("rst_we", 32'(bram_we), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_din", bram_din, 32'd0);
        chk("rst_trig", 32'(trig_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        idle(1);

        // Pulses with no arm are dropped.
        wa.delete(); wd.delete();
        repeat (3) begin
            pulse(32'h55);
            idle(39);
        end
        chk("noarm_writes", 32'(wa.size()), 32'd0);
        chk("noarm_busy", 32'(busy), 32'd0);
        chk("noarm_done", 32'(done), 32'd0);

        // Basic capture: 4 pre samples, timestamp, 3 post samples.
        wa.delete(); wd.delete();
        do_arm(4'd3);
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_done", 32'(done), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            pulse(32'(i));
            idle(2);
        end
        marker(32'hCAFE_0001);
        chk("a_trig", 32'(trig_addr), 32'd4);
        idle(1);
        pulse(32'h5); idle(2);
        pulse(32'h6); idle(2);
        chk("a_mid_done", 32'(done), 32'd0);
        pulse(32'h7);
        chk("a_last_we", 32'(bram_we), 32'd1);
        tick();
        chk("a_done_next", 32'(done), 32'd1);
        chk("a_we_off", 32'(bram_we), 32'd0);
        chk("a_busy_off", 32'(busy), 32'd0);
        pulse(32'h8); idle(2);
        chk("a_nwrites", 32'(wa.size()), 32'd8);
        for (int i = 0; i < 4; i++) chk_wr($sformatf("a_pre%0d", i), i, 4'(i), 32'(i + 1));
        chk_wr("a_ts", 4, 4'd4, 32'hCAFE_0001);
        for (int i = 5; i < 8; i++) chk_wr($sformatf("a_post%0d", i), i, 4'(i), 32'(i));

        // Marker during FILL is ignored; then marker coincident with a sample.
        wa.delete(); wd.delete();
        do_arm(4'd2);
        pulse(32'h11); idle(2);
        pulse(32'h12); idle(2);
        marker(32'h0BAD_0BAD);
        chk("b_fill_marker_we", 32'(bram_we), 32'd0);
        chk("b_fill_marker_trig", 32'(trig_addr), 32'd4);
        idle(1);
        pulse(32'h13); idle(2);
        pulse(32'h14); idle(1);
        cic_40_pulse = 1'b1; iq_data = 32'hAA;
        sec_marker = 1'b1;   timestamp = 32'hBEEF_0002;
        tick();
        cic_40_pulse = 1'b0; sec_marker = 1'b0;
        chk("b_co_we", 32'(bram_we), 32'd1);
        chk("b_co_addr", 32'(bram_addr), 32'd4);
        chk("b_co_din", bram_din, 32'hAA);
        tick();
        chk("b_ts_we", 32'(bram_we), 32'd1);
        chk("b_ts_addr", 32'(bram_addr), 32'd5);
        chk("b_ts_din", bram_din, 32'hBEEF_0002);
        chk("b_trig", 32'(trig_addr), 32'd5);
        pulse(32'h15); idle(2);
        pulse(32'h16);
        tick();
        chk("b_done", 32'(done), 32'd1);
        chk("b_nwrites", 32'(wa.size()), 32'd8);
        chk_wr("b_pre3", 3, 4'd3, 32'h14);
        chk_wr("b_post1", 7, 4'd7, 32'h16);

        // Pointer wrap; post_len 15 clamps to 16-1-4 = 11.
        wa.delete(); wd.delete();
        do_arm(4'd15);
        for (int i = 1; i <= 24; i++) begin
            pulse(32'h100 + 32'(i));
            idle(2);
        end
        chk("c_armed_busy", 32'(busy), 32'd1);
        chk("c_armed_done", 32'(done), 32'd0);
        marker(32'h7777_0005);
        chk("c_trig", 32'(trig_addr), 32'd8);
        for (int k = 1; k <= 13; k++) begin
            pulse(32'h200 + 32'(k));
            idle(2);
        end
        chk("c_done", 32'(done), 32'd1);
        chk("c_busy", 32'(busy), 32'd0);
        chk("c_nwrites", 32'(wa.size()), 32'd36);
        chk_wr("c_pre23", 23, 4'd7, 32'h118);
        chk_wr("c_ts", 24, 4'd8, 32'h7777_0005);
        chk_wr("c_post1", 25, 4'd9, 32'h201);
        chk_wr("c_post7", 31, 4'd15, 32'h207);
        chk_wr("c_post8_wrap", 32, 4'd0, 32'h208);
        chk_wr("c_post11", 35, 4'd3, 32'h20B);

        // Abort beats arm; arm ignored in POST; abort mid-POST then re-arm.
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        chk("d_abort_arm_busy", 32'(busy), 32'd0);
        chk("d_abort_arm_done", 32'(done), 32'd0);
        do_arm(4'd5);
        for (int i = 1; i <= 4; i++) begin
            pulse(32'h30 + 32'(i));
            idle(2);
        end
        marker(32'hDEAD_0003);
        chk("d_trig1", 32'(trig_addr), 32'd4);
        do_arm(4'd0);
        pulse(32'h35);
        chk("d_arm_ignored_addr", 32'(bram_addr), 32'd5);
        idle(2);
        abort = 1'b1; cic_40_pulse = 1'b1; iq_data = 32'h99;
        tick();
        abort = 1'b0; cic_40_pulse = 1'b0;
        chk("d_abort_we", 32'(bram_we), 32'd0);
        chk("d_abort_busy", 32'(busy), 32'd0);
        chk("d_abort_done", 32'(done), 32'd0);
        chk("d_abort_trig", 32'(trig_addr), 32'd4);
        idle(1);
        do_arm(4'd1);
        chk("d_rearm_busy", 32'(busy), 32'd1);
        chk("d_rearm_done", 32'(done), 32'd0);
        pulse(32'h41);
        chk("d_fill_we", 32'(bram_we), 32'd1);
        chk("d_fill_addr", 32'(bram_addr), 32'd0);
        chk("d_fill_din", bram_din, 32'h41);
        chk("d_trig_kept", 32'(trig_addr), 32'd4);
        idle(2);
        for (int i = 2; i <= 5; i++) begin
            pulse(32'h40 + 32'(i));
            idle(2);
        end
        marker(32'h0BAD_0004);
        chk("d_trig2", 32'(trig_addr), 32'd5);
        chk("d_ts_din", bram_din, 32'h0BAD_0004);
        idle(1);
        pulse(32'h46);
        chk("d_post_addr", 32'(bram_addr), 32'd6);
        tick();
        chk("d_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/qpsk_capture_sequencer.md
Name: qpsk_capture_sequencer

Overview:
- Sequences one IQ capture into the IQ BRAM: circular pre-trigger fill, a timestamp word at the second marker, then a fixed post-trigger run, then stop.
- Sits between the CIC decimator output (cic_40_pulse strobe plus IQ word) and the IQ BRAM write port.
- Software arms it and reads the frozen BRAM plus trig_addr after done.

Parameters:
- ADDR_W, 14, BRAM address width; buffer depth 2**ADDR_W words.
- DATA_W, 32, BRAM word width: {I[15:0], Q[15:0]}; also the timestamp width.
- PRE_LEN, 4096, samples written after arm before triggers are accepted.

Ports:
- clk  in  1  capture clock (adc_clk domain).
- rst  in  1  synchronous, active-high reset.
- cic_40_pulse  in  1  one-cycle sample strobe; iq_data is valid in the same cycle.
- iq_data  in  DATA_W  decimated IQ sample.
- sec_marker  in  1  one-cycle trigger pulse (second marker).
- timestamp  in  DATA_W  time value captured at sec_marker.
- arm  in  1  one-cycle start request.
- abort  in  1  one-cycle cancel.
- post_len  in  ADDR_W  number of samples to write after the timestamp word; latched at arm.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM write address.
- bram_din  out  DATA_W  BRAM write data.
- trig_addr  out  ADDR_W  address of the timestamp word.
- busy  out  1  high in FILL, ARMED and POST.
- done  out  1  high in DONE.

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0.
  - wr_ptr=0, fill_cnt=0, post_cnt=0, ts_pending=0, post_len_q=0.
- States and transitions:
  - IDLE --arm--> FILL.
  - FILL --fill_cnt==PRE_LEN--> ARMED.
  - ARMED --sec_marker--> POST.
  - POST --post_cnt==post_len_q--> DONE.
  - DONE --arm--> FILL.
  - abort in any state -> IDLE next cycle. Pending timestamp is discarded; BRAM contents are left as-is.
- Arm:
  - Accepted only in IDLE or DONE; ignored elsewhere.
  - On accept: wr_ptr=0, fill_cnt=0, post_cnt=0, done=0.
  - post_len_q = min(post_len, 2**ADDR_W-1-PRE_LEN), so one capture never overwrites its own pre-trigger window plus timestamp.
- Sample write (FILL, ARMED, POST):
  - cic_40_pulse at cycle t gives bram_we=1 at t+1, with bram_addr=wr_ptr and bram_din=iq_data registered at t.
  - wr_ptr increments after each write and wraps 2**ADDR_W-1 -> 0.
  - fill_cnt saturates at PRE_LEN.
  - Pulses are ignored in IDLE and DONE.
- Trigger:
  - sec_marker in FILL is ignored.
  - sec_marker in ARMED latches timestamp, sets ts_pending and enters POST.
  - sec_marker in POST or DONE is ignored.
- Timestamp write:
  - Occurs at the first cycle from t+1 onward in which no sample write is scheduled; sample writes have priority, so there is at most one cycle of delay.
  - That cycle: bram_we=1, bram_din=latched timestamp, bram_addr=wr_ptr, trig_addr=wr_ptr; wr_ptr then increments; ts_pending=0.
  - A sample strobed in the same cycle as sec_marker is written before the timestamp.
- Post count:
  - post_cnt counts sample writes after the timestamp write only.
  - When post_cnt reaches post_len_q and no write is pending, go to DONE; bram_we=0 from that cycle.
  - post_len_q=0: DONE immediately after the timestamp write.
- Simultaneous events:
  - abort beats arm, sec_marker and writes; no write is issued in the cycle after abort.
  - arm plus sec_marker in DONE: arm wins and the marker is ignored.
- Input rate: cic_40_pulse spacing is at least 2 clocks, which guarantees a free slot for the timestamp.
- busy and done are registered and mutually exclusive.

Test Plan:
- Reset, then pulses every 40 clocks with no arm -> bram_we stays 0; busy=0, done=0.
- PRE_LEN=4, post_len=3; arm; 4 pulses with data 0x1..0x4; sec_marker with timestamp=0xCAFE0001; 3 pulses with data 0x5..0x7 -> expected results:
  - writes at addr 0..3 = 1..4, addr 4 = 0xCAFE0001, addr 5..7 = 5..7.
  - trig_addr=4; done=1 one cycle after the last write; no further writes.
- sec_marker during FILL (after 2 pulses) -> ignored; state reaches ARMED only after 4 samples; trig_addr set only by a later marker.
- sec_marker and cic_40_pulse in the same cycle, data 0xAA -> sample 0xAA written at p at t+1, timestamp at p+1 at t+2; trig_addr=p+1.
- ADDR_W=4, PRE_LEN=4, post_len=15 -> post_len_q=11. Stay ARMED for 20 pulses, then trigger -> wr_ptr wraps 15->0; total post writes=11; done=1.
- abort mid-POST, then arm -> IDLE next cycle, then FILL from addr 0; done=0; prior trig_addr retained until the next timestamp write.
